// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: preamble/SFD hunt, dibit-to-byte assembly, CRC-32 check, frame status and counters.
// Latency: rx_valid/rx_eof rise 2 clk_50MHz cycles after the 4th dibit / first CRS low on the pins.
// Backpressure: none; the sink must take every rx_valid byte, and there is no stall path to the PHY.
module rmii_rx_deframer #(
    parameter int PRE_MIN = 8,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk_50MHz,
    input  logic        reset_n,
    input  logic        CRS,
    input  logic        RX0,
    input  logic        RX1,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic [2:0]  rx_err,
    output logic [10:0] rx_len,
    output logic [15:0] rx_good_cnt,
    output logic [15:0] rx_bad_cnt
);

    localparam int              PCW         = $clog2(PRE_MIN + 1);
    localparam logic [PCW-1:0]  PRE_SAT     = PCW'(PRE_MIN);
    localparam logic [10:0]     LEN_MIN     = 11'(MIN_LEN);
    localparam logic [10:0]     LEN_MAX     = 11'(MAX_LEN);
    localparam logic [10:0]     LEN_SAT     = 11'h7FF;
    localparam logic [31:0]     CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0]     CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {WAIT_IDLE, HUNT, PREAMBLE, DATA} state_t;

    state_t          state, state_nxt;
    logic            crs_q;
    logic [1:0]      dib_q;
    logic [PCW-1:0]  pre_cnt;
    logic [1:0]      phase;
    logic [5:0]      shift_q;
    logic [10:0]     len_q;
    logic [31:0]     crc_q;
    logic            giant;

    logic            pre_load, pre_inc, start, shift_en, emit, set_giant, eof;
    logic [7:0]      cur_byte;
    logic [10:0]     len_inc;
    logic [2:0]      err_now;

    // Byte-wise reflected CRC-32 update, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // Earlier dibits sit in shift_q, the current one completes the byte MSB-side.
    assign cur_byte = {dib_q, shift_q};
    assign len_inc  = (len_q == LEN_SAT) ? len_q : len_q + 11'd1;
    assign err_now  = {phase != 2'd0,
                       (len_q < LEN_MIN) || (len_q > LEN_MAX),
                       crc_q != CRC_RESIDUE};

    // PHY pins registered once; crs_q resets high so a frame already in flight
    // at reset release is ignored until the line has actually gone idle.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            crs_q <= 1'b1;
            dib_q <= 2'b00;
        end else begin
            crs_q <= CRS;
            dib_q <= {RX1, RX0};
        end
    end

    // FSM state register.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) state <= WAIT_IDLE;
        else          state <= state_nxt;
    end

    // Next-state and per-cycle control strobes for the datapath.
    always_comb begin
        state_nxt = state;
        pre_load  = 1'b0;
        pre_inc   = 1'b0;
        start     = 1'b0;
        shift_en  = 1'b0;
        emit      = 1'b0;
        set_giant = 1'b0;
        eof       = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (!crs_q) state_nxt = HUNT;
            end
            HUNT: begin
                if (crs_q) begin
                    if (dib_q == 2'b01) begin
                        pre_load  = 1'b1;
                        state_nxt = PREAMBLE;
                    end else begin
                        state_nxt = WAIT_IDLE;
                    end
                end
            end
            PREAMBLE: begin
                if (!crs_q) begin
                    state_nxt = HUNT;
                end else if (dib_q == 2'b01) begin
                    pre_inc = 1'b1;
                end else if (dib_q == 2'b11 && pre_cnt >= PRE_SAT) begin
                    start     = 1'b1;
                    state_nxt = DATA;
                end else begin
                    state_nxt = WAIT_IDLE;
                end
            end
            DATA: begin
                if (!crs_q) begin
                    eof       = 1'b1;
                    state_nxt = HUNT;
                end else if (!giant) begin
                    shift_en = 1'b1;
                    if (phase == 2'd3) begin
                        if (len_q == LEN_MAX) set_giant = 1'b1;
                        else                  emit      = 1'b1;
                    end
                end
            end
            default: state_nxt = WAIT_IDLE;
        endcase
    end

    // Preamble counter, saturating once the minimum has been met.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n)                        pre_cnt <= '0;
        else if (pre_load)                   pre_cnt <= PCW'(1);
        else if (pre_inc && pre_cnt != PRE_SAT) pre_cnt <= pre_cnt + PCW'(1);
    end

    // Frame datapath: byte assembly, CRC, length and the giant freeze.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            phase   <= 2'd0;
            shift_q <= 6'd0;
            len_q   <= 11'd0;
            crc_q   <= 32'hFFFFFFFF;
            giant   <= 1'b0;
        end else if (start) begin
            phase <= 2'd0;
            len_q <= 11'd0;
            crc_q <= 32'hFFFFFFFF;
            giant <= 1'b0;
        end else begin
            if (shift_en) begin
                shift_q <= {dib_q, shift_q[5:2]};
                phase   <= phase + 2'd1;
            end
            if (emit) begin
                crc_q <= crc_byte(crc_q, cur_byte);
                len_q <= len_inc;
            end
            if (set_giant) begin
                giant <= 1'b1;
                len_q <= len_inc;
            end
        end
    end

    // Output strobes, held status and frame counters.
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            rx_data     <= 8'd0;
            rx_valid    <= 1'b0;
            rx_sof      <= 1'b0;
            rx_eof      <= 1'b0;
            rx_err      <= 3'd0;
            rx_len      <= 11'd0;
            rx_good_cnt <= 16'd0;
            rx_bad_cnt  <= 16'd0;
        end else begin
            rx_valid <= emit;
            rx_sof   <= emit && (len_q == 11'd0);
            rx_eof   <= eof;
            if (emit) rx_data <= cur_byte;
            if (eof) begin
                rx_err <= err_now;
                rx_len <= len_q;
                if (err_now == 3'd0) rx_good_cnt <= rx_good_cnt + 16'd1;
                else                 rx_bad_cnt  <= rx_bad_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Bench for rmii_rx_deframer: frame table plus reset-mid-frame sequence, scoreboarded bytes and end-of-frame status.
// Latency: checks rx_sof and rx_eof arrive 2 cycles after the driving pin event.
// Backpressure: none; every strobe is consumed by the monitor as it appears.
module tb_rmii_rx_deframer;

    logic        clk_50MHz = 1'b0;
    logic        reset_n   = 1'b0;
    logic        CRS = 1'b0, RX0 = 1'b0, RX1 = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof;
    logic [2:0]  rx_err;
    logic [10:0] rx_len;
    logic [15:0] rx_good_cnt, rx_bad_cnt;

    rmii_rx_deframer dut (
        .clk_50MHz  (clk_50MHz),
        .reset_n    (reset_n),
        .CRS        (CRS),
        .RX0        (RX0),
        .RX1        (RX1),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_sof     (rx_sof),
        .rx_eof     (rx_eof),
        .rx_err     (rx_err),
        .rx_len     (rx_len),
        .rx_good_cnt(rx_good_cnt),
        .rx_bad_cnt (rx_bad_cnt)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    int cyc = 0;
    always @(posedge clk_50MHz) cyc <= cyc + 1;

    typedef struct {
        int        n;        // frame bytes incl. FCS
        int        pre;      // 0 normal, 1 contains 0x54, 2 only four 01 dibits
        int        flip;     // byte index to corrupt after FCS, -1 none
        int        cut;      // data dibits actually sent, -1 all
        int        nbytes;   // expected rx_valid strobes
        bit        eof;      // rx_eof expected
        logic [2:0] err;
        logic [2:0] mask;
        int        len;
        bit        chk_len;
    } case_t;

    typedef struct { logic [7:0] data; bit sof; } byte_rec_t;
    typedef struct { logic [2:0] err; logic [2:0] mask; int len; bit chk_len; int good; int bad; } eof_rec_t;

    byte_rec_t  bq[$];
    eof_rec_t   eq[$];
    case_t      tbl[10];
    logic [7:0] fb[0:1599];

    int n_chk = 0, n_pass = 0;
    int exp_good = 0, exp_bad = 0;
    int sof_cyc = 0, drop_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Frame body: broadcast DA, fixed SA, type 0800, patterned payload, Ethernet FCS.
    task automatic build_frame(input int n, input int flip);
        logic [7:0]  hdr[14];
        logic [31:0] c;
        hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hBA, 8'hBE, 8'h08, 8'h00};
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            fb[i] = (i < 14) ? hdr[i] : 8'((i * 7 + 3) & 255);
            c = crc_upd(c, fb[i]);
        end
        if (n >= 4) begin
            c = ~c;
            for (int k = 0; k < 4; k++) fb[n - 4 + k] = c[8*k +: 8];
        end
        if (flip >= 0) fb[flip] = fb[flip] ^ 8'h10;
    endtask

    task automatic dib(input logic crs, input logic [1:0] d);
        @(negedge clk_50MHz);
        CRS = crs; RX0 = d[0]; RX1 = d[1];
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int j = 0; j < 4; j++) dib(1'b1, b[2*j +: 2]);
    endtask

    task automatic idle(input int n);
        repeat (n) dib(1'b0, 2'b00);
    endtask

    task automatic send_preamble(input int pre);
        logic [7:0] p1[8];
        if (pre == 2) begin
            repeat (4) dib(1'b1, 2'b01);
            dib(1'b1, 2'b11);
        end else begin
            p1 = '{8'h55, 8'h55, 8'h54, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5};
            for (int i = 0; i < 8; i++) send_byte((pre == 1 || i == 7) ? p1[i] : 8'h55);
        end
    endtask

    task automatic send_frame(input int n, input int pre, input int cut);
        int total;
        send_preamble(pre);
        total = (cut >= 0) ? cut : n * 4;
        for (int k = 0; k < total; k++) begin
            dib(1'b1, fb[k / 4][2 * (k % 4) +: 2]);
            if (k == 3) sof_cyc = cyc;
        end
        dib(1'b0, 2'b00);
        drop_cyc = cyc;
    endtask

    task automatic run_case(input int idx, input case_t c);
        eof_rec_t e;
        build_frame(c.n, c.flip);
        for (int i = 0; i < c.nbytes; i++) bq.push_back('{fb[i], i == 0});
        if (c.eof) begin
            if (c.err == 3'd0) exp_good++; else exp_bad++;
            e = '{c.err, c.mask, c.len, c.chk_len, exp_good, exp_bad};
            eq.push_back(e);
        end
        send_frame(c.n, c.pre, c.cut);
        idle(16);
        check($sformatf("case%0d_bytes_missing", idx), bq.size(), 0);
        check($sformatf("case%0d_eof_missing", idx), eq.size(), 0);
        check($sformatf("case%0d_good_cnt", idx), rx_good_cnt, exp_good);
        check($sformatf("case%0d_bad_cnt", idx), rx_bad_cnt, exp_bad);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk_50MHz) begin
        if (reset_n) begin
            byte_rec_t br;
            eof_rec_t  er;
            if (rx_valid && rx_eof) check("valid_with_eof", 1, 0);
            if (rx_valid) begin
                if (bq.size() == 0) check("stray_byte", {24'd0, rx_data}, 32'hFFFF_FFFF);
                else begin
                    br = bq.pop_front();
                    check("byte_data", rx_data, br.data);
                    check("byte_sof", rx_sof, br.sof);
                    if (br.sof) check("sof_latency", cyc, sof_cyc + 2);
                end
            end else if (rx_sof) check("sof_without_valid", 1, 0);
            if (rx_eof) begin
                if (eq.size() == 0) check("stray_eof", {29'd0, rx_err}, 32'hFFFF_FFFF);
                else begin
                    er = eq.pop_front();
                    check("eof_err", rx_err & er.mask, er.err & er.mask);
                    if (er.chk_len) check("eof_len", rx_len, er.len);
                    check("eof_good_cnt", rx_good_cnt, er.good);
                    check("eof_bad_cnt", rx_bad_cnt, er.bad);
                    check("eof_latency", cyc, drop_cyc + 2);
                end
            end
        end
    end

    initial begin
        //          n     pre flip cut  nbytes eof err     mask    len   chk_len
        tbl[0] = '{64,   0,  -1,  -1,  64,    1,  3'b000, 3'b111, 64,   1};
        tbl[1] = '{64,   0,  30,  -1,  64,    1,  3'b001, 3'b111, 64,   1};
        tbl[2] = '{40,   0,  -1,  -1,  40,    1,  3'b010, 3'b111, 40,   1};
        tbl[3] = '{63,   0,  -1,  -1,  63,    1,  3'b010, 3'b111, 63,   1};
        tbl[4] = '{0,    0,  -1,   0,  0,     1,  3'b011, 3'b111, 0,    1};
        tbl[5] = '{1600, 0,  -1,  -1,  1518,  1,  3'b010, 3'b010, 0,    0};
        tbl[6] = '{100,  0,  -1,  278, 69,    1,  3'b100, 3'b110, 69,   1};
        tbl[7] = '{64,   1,  -1,  -1,  0,     0,  3'b000, 3'b000, 0,    0};
        tbl[8] = '{64,   2,  -1,  -1,  0,     0,  3'b000, 3'b000, 0,    0};
        tbl[9] = '{64,   0,  -1,  -1,  64,    1,  3'b000, 3'b111, 64,   1};

        repeat (3) @(negedge clk_50MHz);
        check("rst_valid", rx_valid, 0);
        check("rst_eof", rx_eof, 0);
        check("rst_data", rx_data, 0);
        check("rst_err", rx_err, 0);
        check("rst_len", rx_len, 0);
        check("rst_good", rx_good_cnt, 0);
        check("rst_bad", rx_bad_cnt, 0);
        reset_n = 1'b1;
        idle(10);

        for (int i = 0; i < 10; i++) run_case(i, tbl[i]);

        // Reset during byte 20 with CRS held high: 19 bytes out, then silence.
        build_frame(64, -1);
        for (int i = 0; i < 19; i++) bq.push_back('{fb[i], i == 0});
        send_preamble(0);
        for (int k = 0; k < 256; k++) begin
            dib(1'b1, fb[k / 4][2 * (k % 4) +: 2]);
            if (k == 3) sof_cyc = cyc;
            if (k == 78) begin
                check("rst_mid_bytes_done", bq.size(), 0);
                reset_n = 1'b0;
                exp_good = 0;
                exp_bad  = 0;
            end
            if (k == 79) begin
                check("rst_mid_valid", rx_valid, 0);
                check("rst_mid_data", rx_data, 0);
                check("rst_mid_good", rx_good_cnt, 0);
                check("rst_mid_bad", rx_bad_cnt, 0);
            end
            if (k == 80) reset_n = 1'b1;
        end
        dib(1'b0, 2'b00);
        idle(16);
        check("rst_tail_eof", eq.size(), 0);
        check("rst_tail_good", rx_good_cnt, 0);
        check("rst_tail_bad", rx_bad_cnt, 0);

        run_case(10, tbl[0]);
        check("post_rst_good_is_1", rx_good_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
